hub75_panel_rx: RTL and testbench
=================================

Name: hub75_panel_rx

Overview:
- Receive-side model of the LED panel interface driven by led_shifter. It behaves as the panel's column shift registers and row latch.
- Oversamples led_clk, led_latch, led_oe, dmux and RGB data on the fabric clock. It shifts in column data, and on each latch pulse it emits the captured row as a pixel stream with a valid/ready handshake.
- Used as a loopback checker and panel emulator: led_shifter output pins connect straight to its inputs.

Parameters:
- COLS, 64, columns per row (shift register depth); COL_W = clog2(COLS).
- ROW_BITS, 4, width of dmux row address.
- SYNC_STAGES, 2, synchroniser flops on every panel-side input (minimum 2).

Ports:
- clk  in  1  fabric clock; every panel input is sampled on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- led_clk  in  1  panel shift clock; data is shifted on its rising edge.
- led_latch  in  1  panel latch; the row is transferred on its rising edge.
- led_oe  in  1  panel output enable, active low (0 = display lit).
- dmux  in  ROW_BITS  row address.
- rgb  in  6  {r0,g0,b0,r1,g1,b1} column data.
- clr_flags  in  1  one-cycle pulse that clears the sticky flags.
- pix_valid  out  1  stream data valid.
- pix_ready  in  1  stream consumer ready.
- pix_row  out  ROW_BITS  row address of the current pixel.
- pix_col  out  COL_W  column of the current pixel.
- pix_rgb  out  6  pixel data.
- row_done  out  1  one-cycle pulse on the handshake of the last pixel (col COLS-1).
- short_row  out  1  sticky: a latch arrived after a shift count other than COLS.
- overrun  out  1  sticky: a latch arrived while the previous row was still streaming.
- latch_while_on  out  1  sticky: a latch arrived while synchronised led_oe = 0.

Behaviour:
- Reset: all outputs 0; synchronisers, shift register, hold buffer and counters cleared; FSM in IDLE.
- Synchronisation: every panel input passes through SYNC_STAGES flops, and the data used is the synchronised copy. Edge detection compares the last synchroniser stage with one extra flop. Input-to-edge-detect latency is SYNC_STAGES+1 clk cycles.
- led_clk rising edge:
  - sr shifts up: sr[i] <= sr[i-1], sr[0] <= synced rgb.
  - After exactly COLS shifts, sr[c] holds column c, so the first value shifted lands at column COLS-1.
  - shift_cnt increments and saturates at COLS+1.
- led_latch rising edge:
  - If an led_clk edge is detected in the same cycle, the shift is applied first and the latched row includes that bit.
  - short_row <= 1 if shift_cnt != COLS.
  - latch_while_on <= 1 if synced led_oe == 0.
  - shift_cnt is reset to 0; sr keeps its contents.
  - In IDLE: hold <= sr (post-shift), row_reg <= synced dmux, go to STREAM with col = 0.
  - In STREAM: the latch is dropped, overrun <= 1, and the hold buffer is left unchanged.
- FSM IDLE:
  - pix_valid = 0.
  - Moves to STREAM on a latch edge; pix_valid rises the cycle after the edge detect.
- FSM STREAM:
  - pix_valid = 1; pix_col = col; pix_rgb = hold[col]; pix_row = row_reg.
  - Outputs are stable while pix_valid && !pix_ready.
  - On handshake: col increments. If col == COLS-1, row_done pulses in that same cycle and the FSM returns to IDLE.
  - A new latch can be accepted in the cycle after the return to IDLE. A latch in the final handshake cycle is an overrun.
- Sticky flags: cleared by clr_flags. If a set event and clr_flags occur in the same cycle, the set wins.
- Reset mid-stream: the stream is abandoned immediately and pix_valid drops asynchronously.
- dmux and oe changes without a latch have no effect, apart from being sampled at the latch edge.

Test Plan:
- Reset, then shift 64 columns with rgb = column index[5:0] (first shifted = 63), then latch with dmux = 5. Hold pix_ready = 1. Expect 64 beats: pix_row = 5, pix_col 0..63, pix_rgb = col; row_done on col 63; all flags 0.
- Same row with pix_ready toggled 1/0 each cycle -> 64 beats, no loss or duplication, data held stable during stalls, 128±1 cycles from first valid to row_done.
- Shift 63 columns then latch -> short_row = 1, stream still 64 beats. Pulse clr_flags -> short_row = 0. Then shift 70 columns and latch -> short_row = 1.
- Latch a second time while pix_ready = 0 mid-stream -> overrun = 1, and the stream continues with the first row's data and row address.
- Latch with led_oe = 0 -> latch_while_on = 1. Latch with led_oe = 1 -> flag unchanged.
- Assert rst_n = 0 at column 20 of a stream -> pix_valid = 0 immediately and all flags 0. After release, a fresh 64-shift row streams correctly.

Source files
------------

// File: rtl/hub75_panel_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_panel_rx
// Purpose  : Receive-side emulation of a HUB75 LED panel. It oversamples the
//            panel pins on the fabric clock, behaves as the column shift
//            register and the row latch, and replays each latched row as a
//            valid/ready pixel stream. It also raises sticky protocol flags.
// Ports    :
//   clk, rst_n           fabric clock, asynchronous active-low reset
//   led_clk, led_latch   panel shift clock and row latch (asynchronous)
//   led_oe               panel output enable, active low
//   dmux [ROW_BITS]      row address
//   rgb  [6]             {r0,g0,b0,r1,g1,b1} column data
//   clr_flags            one-cycle pulse clearing the sticky flags
//   pix_valid/pix_ready  pixel stream handshake
//   pix_row/pix_col/pix_rgb  row address, column and data of the pixel
//   row_done             pulse on the handshake of the last column
//   short_row, overrun, latch_while_on  sticky protocol flags
// Revision : 1.0  initial release
// ============================================================================
module hub75_panel_rx #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          led_clk,
  input  logic                          led_latch,
  input  logic                          led_oe,
  input  logic [ROW_BITS-1:0]           dmux,
  input  logic [5:0]                    rgb,
  input  logic                          clr_flags,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [ROW_BITS-1:0]           pix_row,
  output logic [$clog2(COLS)-1:0]       pix_col,
  output logic [5:0]                    pix_rgb,
  output logic                          row_done,
  output logic                          short_row,
  output logic                          overrun,
  output logic                          latch_while_on
);

  localparam int COL_W  = $clog2(COLS);
  // shift_cnt must be able to hold COLS+1 (saturation value)
  localparam int CNT_W  = $clog2(COLS + 2);
  localparam int IN_W   = 3 + ROW_BITS + 6;
  // Fewer than two stages would not be a synchroniser at all
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // --------------------------------------------------------------------------
  // Input synchroniser: all panel pins travel through the same pipeline so
  // data, address and strobes stay aligned with each other.
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] raw;
  logic [IN_W-1:0] sync_q [STAGES];

  assign raw = {led_clk, led_latch, led_oe, dmux, rgb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic                s_clk;
  logic                s_latch;
  logic                s_oe;
  logic [ROW_BITS-1:0] s_dmux;
  logic [5:0]          s_rgb;

  assign s_clk   = sync_q[STAGES-1][IN_W-1];
  assign s_latch = sync_q[STAGES-1][IN_W-2];
  assign s_oe    = sync_q[STAGES-1][IN_W-3];
  assign s_dmux  = sync_q[STAGES-1][6 +: ROW_BITS];
  assign s_rgb   = sync_q[STAGES-1][5:0];

  // Edge detection against one extra flop after the last stage
  logic clk_prev;
  logic latch_prev;
  logic clk_rise;
  logic latch_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev   <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      clk_prev   <= s_clk;
      latch_prev <= s_latch;
    end
  end

  assign clk_rise   = s_clk & ~clk_prev;
  assign latch_rise = s_latch & ~latch_prev;

  // --------------------------------------------------------------------------
  // Column shift register. sr_next is the post-shift view so a latch seen in
  // the same cycle as a shift captures the freshly shifted column too.
  // --------------------------------------------------------------------------
  logic [5:0] sr      [COLS];
  logic [5:0] sr_next [COLS];

  always_comb begin
    sr_next[0] = clk_rise ? s_rgb : sr[0];
    for (int i = 1; i < COLS; i++) begin
      sr_next[i] = clk_rise ? sr[i-1] : sr[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) sr[i] <= '0;
    end else begin
      for (int i = 0; i < COLS; i++) sr[i] <= sr_next[i];
    end
  end

  // Shift counter, saturating at COLS+1 so "too many" stays distinguishable
  logic [CNT_W-1:0] shift_cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = shift_cnt;
    if (clk_rise && (shift_cnt != CNT_W'(COLS + 1))) begin
      cnt_next = shift_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt <= '0;
    end else if (latch_rise) begin
      shift_cnt <= '0;
    end else begin
      shift_cnt <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Stream FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [COL_W-1:0] col;
  logic             load;
  logic             col_inc;
  logic             overrun_set;
  logic             last_col;

  assign last_col = (col == COL_W'(COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    pix_valid   = 1'b0;
    load        = 1'b0;
    col_inc     = 1'b0;
    row_done    = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (latch_rise) begin
          load     = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        pix_valid = 1'b1;
        // A latch while streaming (including the final beat) is dropped
        overrun_set = latch_rise;
        if (pix_ready) begin
          col_inc = 1'b1;
          if (last_col) begin
            row_done = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Column pointer and row hold buffer
  logic [5:0]          hold [COLS];
  logic [ROW_BITS-1:0] row_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
    end else if (load) begin
      col <= '0;
    end else if (col_inc) begin
      col <= last_col ? '0 : col + COL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++) hold[i] <= '0;
      row_reg <= '0;
    end else if (load) begin
      for (int i = 0; i < COLS; i++) hold[i] <= sr_next[i];
      row_reg <= s_dmux;
    end
  end

  assign pix_col = col;
  assign pix_rgb = hold[col];
  assign pix_row = row_reg;

  // --------------------------------------------------------------------------
  // Sticky flags: a set event beats a simultaneous clear
  // --------------------------------------------------------------------------
  logic short_set;
  logic lwo_set;

  assign short_set = latch_rise && (cnt_next != CNT_W'(COLS));
  assign lwo_set   = latch_rise && !s_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_row      <= 1'b0;
      overrun        <= 1'b0;
      latch_while_on <= 1'b0;
    end else begin
      short_row      <= short_set   | (short_row      & ~clr_flags);
      overrun        <= overrun_set | (overrun        & ~clr_flags);
      latch_while_on <= lwo_set     | (latch_while_on & ~clr_flags);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_panel_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hub75_panel_rx
// Purpose  : Self-checking bench for hub75_panel_rx. Rows are shifted in with a
//            reference shift-register model; every accepted latch pushes the
//            expected 64 beats into a scoreboard queue which a monitor pops on
//            each handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_hub75_panel_rx;

  localparam int COLS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       led_clk = 1'b0;
  logic       led_latch = 1'b0;
  logic       led_oe = 1'b1;
  logic [3:0] dmux = '0;
  logic [5:0] rgb = '0;
  logic       clr_flags = 1'b0;
  logic       pix_ready = 1'b0;
  logic       pix_valid;
  logic [3:0] pix_row;
  logic [5:0] pix_col;
  logic [5:0] pix_rgb;
  logic       row_done;
  logic       short_row;
  logic       overrun;
  logic       latch_while_on;

  hub75_panel_rx #(.COLS(COLS), .ROW_BITS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .led_clk(led_clk), .led_latch(led_latch),
    .led_oe(led_oe), .dmux(dmux), .rgb(rgb), .clr_flags(clr_flags),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row),
    .pix_col(pix_col), .pix_rgb(pix_rgb), .row_done(row_done),
    .short_row(short_row), .overrun(overrun), .latch_while_on(latch_while_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] row;
    logic [5:0] col;
    logic [5:0] rgb;
  } beat_t;

  typedef struct {
    int         nshift;
    int         seed;
    logic [3:0] row;
    logic       oe;
    int         rmode;
    bit         clr;
    bit         exp_short;
    bit         exp_lwo;
    bit         timing;
  } vec_t;

  beat_t      exp_q[$];
  logic [5:0] msr [COLS];
  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int cyc = 0;
  int in_row = 0;
  int start_cyc = 0;
  int last_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = stalled
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor, sampling 3 ns before the rising edge
  always @(negedge clk) begin : mon
    beat_t e;
    #2;
    cyc++;
    if (rst_n) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual col=%0d required none", pix_col);
        end else begin
          e = exp_q[0];
          chk("pix_row", pix_row, e.row);
          chk("pix_col", pix_col, e.col);
          chk("pix_rgb", pix_rgb, e.rgb);
          chk("row_done", row_done, (pix_ready && e.col == 6'd63));
          if (in_row == 0) begin
            in_row = 1;
            start_cyc = cyc;
          end
          if (pix_ready) begin
            if (e.col == 6'd63) begin
              last_len = cyc - start_cyc + 1;
              in_row = 0;
            end
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("row_done_idle", row_done, 0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_in(input logic [5:0] d);
    @(negedge clk);
    rgb = d;
    led_clk = 1'b1;
    cycles(2);
    led_clk = 1'b0;
    cycles(2);
    for (int i = COLS - 1; i > 0; i--) msr[i] = msr[i-1];
    msr[0] = d;
  endtask

  // First value shifted lands at column 63; with seed 0 column c holds c
  task automatic shift_row(input int n, input int seed);
    for (int k = 0; k < n; k++) shift_in(6'((63 - k + seed) & 63));
  endtask

  task automatic latch(input logic [3:0] row, input logic oe, input bit accept);
    beat_t b;
    @(negedge clk);
    dmux = row;
    led_oe = oe;
    led_latch = 1'b1;
    if (accept) begin
      for (int c = 0; c < COLS; c++) begin
        b.row = row;
        b.col = 6'(c);
        b.rgb = msr[c];
        exp_q.push_back(b);
      end
    end
    cycles(2);
    led_latch = 1'b0;
    cycles(2);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pix_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain_in_time", (n < 2000), 1);
    cycles(2);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #3;
    chk("clr_short_row", short_row, 0);
    chk("clr_overrun", overrun, 0);
    chk("clr_latch_while_on", latch_while_on, 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[7];

  initial begin : main
    int n;
    tbl[0] = '{nshift:64, seed:0,  row:4'd5,  oe:1'b1, rmode:0, clr:1'b0, exp_short:1'b0, exp_lwo:1'b0, timing:1'b0};
    tbl[1] = '{nshift:64, seed:0,  row:4'd5,  oe:1'b1, rmode:1, clr:1'b0, exp_short:1'b0, exp_lwo:1'b0, timing:1'b1};
    tbl[2] = '{nshift:63, seed:7,  row:4'd3,  oe:1'b1, rmode:0, clr:1'b0, exp_short:1'b1, exp_lwo:1'b0, timing:1'b0};
    tbl[3] = '{nshift:64, seed:11, row:4'd7,  oe:1'b1, rmode:0, clr:1'b1, exp_short:1'b0, exp_lwo:1'b0, timing:1'b0};
    tbl[4] = '{nshift:70, seed:25, row:4'd9,  oe:1'b1, rmode:0, clr:1'b0, exp_short:1'b1, exp_lwo:1'b0, timing:1'b0};
    tbl[5] = '{nshift:64, seed:33, row:4'd2,  oe:1'b0, rmode:0, clr:1'b1, exp_short:1'b0, exp_lwo:1'b1, timing:1'b0};
    tbl[6] = '{nshift:64, seed:40, row:4'd12, oe:1'b1, rmode:0, clr:1'b0, exp_short:1'b0, exp_lwo:1'b1, timing:1'b0};

    for (int i = 0; i < COLS; i++) msr[i] = '0;

    // Reset state
    rst_n = 1'b0;
    cycles(3);
    #3;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_col", pix_col, 0);
    chk("rst_pix_rgb", pix_rgb, 0);
    chk("rst_pix_row", pix_row, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_short_row", short_row, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_latch_while_on", latch_while_on, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Table-driven rows
    for (int v = 0; v < 7; v++) begin
      ready_mode = tbl[v].rmode;
      if (tbl[v].clr) pulse_clr();
      shift_row(tbl[v].nshift, tbl[v].seed);
      latch(tbl[v].row, tbl[v].oe, 1'b1);
      drain();
      chk($sformatf("v%0d_short_row", v), short_row, tbl[v].exp_short);
      chk($sformatf("v%0d_latch_while_on", v), latch_while_on, tbl[v].exp_lwo);
      chk($sformatf("v%0d_overrun", v), overrun, 0);
      if (tbl[v].timing) begin
        chk("stall_len_min", (last_len >= 127), 1);
        chk("stall_len_max", (last_len <= 129), 1);
      end
      ready_mode = 0;
    end

    // Overrun: second latch while the first row is stalled mid-stream
    pulse_clr();
    ready_mode = 2;
    shift_row(64, 50);
    latch(4'hA, 1'b1, 1'b1);
    cycles(10);
    latch(4'h6, 1'b1, 1'b0);
    cycles(4);
    #3;
    chk("ovr_overrun", overrun, 1);
    chk("ovr_still_valid", pix_valid, 1);
    ready_mode = 0;
    drain();
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of a stream
    pulse_clr();
    shift_row(64, 3);
    latch(4'h1, 1'b0, 1'b1);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      #3;
      if (pix_valid && pix_col == 6'd20) break;
      n++;
    end
    chk("mid_reach_col20", (n < 300), 1);
    chk("mid_lwo_before_reset", latch_while_on, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_short_row", short_row, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_latch_while_on", latch_while_on, 0);
    exp_q.delete();
    in_row = 0;
    for (int i = 0; i < COLS; i++) msr[i] = '0;
    led_oe = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    shift_row(64, 0);
    latch(4'h8, 1'b1, 1'b1);
    drain();
    chk("post_rst_short_row", short_row, 0);
    chk("post_rst_overrun", overrun, 0);
    chk("post_rst_latch_while_on", latch_while_on, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
